// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: valid/ready handshake, optional two-entry skid buffer,
// flush-to-NOP and a saturating count of downstream bubble cycles.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] NOP_VAL = '0,
  parameter int unsigned      SKID    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_nxt;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_nxt;
  logic             ready_q;
  logic             ready_nxt;
  logic             valid_nxt;
  logic             in_fire;
  logic             out_fire;

  // With a skid entry, ready comes from a flop so it never sees out_ready combinationally.
  assign in_ready = (SKID != 0) ? ready_q : (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and next-payload selection; flush overrides all handshake activity.
  always_comb begin
    state_nxt = state;
    main_nxt  = out_data;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = NOP_VAL;
      skid_nxt  = NOP_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            // Without a skid entry ready implies out_ready, so this arm is SKID-only.
            if (SKID != 0) begin
              skid_nxt  = in_data;
              state_nxt = FULL;
            end else begin
              main_nxt = in_data;
            end
          end else if (out_fire) begin
            main_nxt  = NOP_VAL;
            state_nxt = EMPTY;
          end else begin
            state_nxt = ONE;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_nxt  = skid_q;
            skid_nxt  = NOP_VAL;
            state_nxt = ONE;
          end else begin
            state_nxt = FULL;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = NOP_VAL;
          skid_nxt  = NOP_VAL;
        end
      endcase
    end
    ready_nxt = (state_nxt != FULL);
    valid_nxt = (state_nxt != EMPTY);
  end

  // State, payload and registered handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= NOP_VAL;
      skid_q    <= NOP_VAL;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_data  <= main_nxt;
      skid_q    <= skid_nxt;
      ready_q   <= ready_nxt;
    end
  end

  // Saturating bubble counter; flush does not clear it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bubble_cnt <= 16'd0;
    end else if (out_ready && !out_valid && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance
// driven from shared inputs, with directed tables, hand sequences and a queue model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = 32'd0;

  logic        ir1, ov1, ir0, ov0;
  logic [31:0] od1, od0;
  logic [15:0] bc1, bc0;

  int errors = 0;
  int checks = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  int          cnt1;
  int          cnt0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .NOP_VAL(32'h0), .SKID(1)) dut1 (
    .CLK(clk), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .bubble_cnt(bc1)
  );

  pipe_stage_reg #(.WIDTH(32), .NOP_VAL(32'h0), .SKID(0)) dut0 (
    .CLK(clk), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .bubble_cnt(bc0)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic [31:0] eod;
    logic        eir;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl,
                              logic eov, logic [31:0] eod, logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eod = eod; v.eir = eir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    q1.delete(); q0.delete();
    cnt1 = 0; cnt0 = 0;
  endtask

  // Queue model update for one clock edge, using the pre-edge model state.
  task automatic model_step();
    bit f1, f0, r1, r0;
    r1 = (q1.size() < 2);
    r0 = (q0.size() == 0) || out_ready;
    if (out_ready && q1.size() == 0 && cnt1 < 65535) cnt1++;
    if (out_ready && q0.size() == 0 && cnt0 < 65535) cnt0++;
    f1 = in_valid && r1;
    f0 = in_valid && r0;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (out_ready && q1.size() > 0) void'(q1.pop_front());
      if (out_ready && q0.size() > 0) void'(q0.pop_front());
      if (f1) q1.push_back(in_data);
      if (f0) q0.push_back(in_data);
    end
  endtask

  initial begin
    // Reset state of both instances.
    do_reset();
    #1;
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_od1", od1, 32'd0);
    check("rst_ir1", 32'(ir1), 32'd1);
    check("rst_bc1", 32'(bc1), 32'd0);
    check("rst_ov0", 32'(ov0), 32'd0);
    check("rst_ir0", 32'(ir0), 32'd1);

    // Stream, backpressure and flush on the SKID=1 instance.
    tbl[0]  = mk(1'b1, 32'd1,  1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[1]  = mk(1'b1, 32'd2,  1'b1, 1'b0, 1'b1, 32'd1, 1'b1);
    tbl[2]  = mk(1'b1, 32'd3,  1'b1, 1'b0, 1'b1, 32'd2, 1'b1);
    tbl[3]  = mk(1'b1, 32'd4,  1'b1, 1'b0, 1'b1, 32'd3, 1'b1);
    tbl[4]  = mk(1'b1, 32'd5,  1'b1, 1'b0, 1'b1, 32'd4, 1'b1);
    tbl[5]  = mk(1'b1, 32'd6,  1'b0, 1'b0, 1'b1, 32'd5, 1'b1);
    tbl[6]  = mk(1'b1, 32'd7,  1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
    tbl[7]  = mk(1'b1, 32'd7,  1'b1, 1'b0, 1'b1, 32'd5, 1'b0);
    tbl[8]  = mk(1'b1, 32'd7,  1'b1, 1'b0, 1'b1, 32'd6, 1'b1);
    tbl[9]  = mk(1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd7, 1'b1);
    tbl[10] = mk(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[11] = mk(1'b1, 32'd8,  1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[12] = mk(1'b1, 32'd9,  1'b0, 1'b0, 1'b1, 32'd8, 1'b1);
    tbl[13] = mk(1'b1, 32'd10, 1'b0, 1'b1, 1'b1, 32'd8, 1'b0);
    tbl[14] = mk(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    tbl[15] = mk(1'b1, 32'd11, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    tbl[16] = mk(1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d;
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      #1;
      check($sformatf("tbl%0d_ov", i), 32'(ov1), 32'(tbl[i].eov));
      check($sformatf("tbl%0d_od", i), od1, tbl[i].eod);
      check($sformatf("tbl%0d_ir", i), 32'(ir1), 32'(tbl[i].eir));
      @(negedge clk);
    end

    // Combinational ready on the SKID=0 instance.
    do_reset();
    in_valid = 1'b1; in_data = 32'd20; out_ready = 1'b1;
    #1 check("c0_ir_empty", 32'(ir0), 32'd1);
    @(negedge clk);
    in_data = 32'd21; out_ready = 1'b0;
    #1;
    check("c0_ov", 32'(ov0), 32'd1);
    check("c0_od20", od0, 32'd20);
    check("c0_ir_stall", 32'(ir0), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("c0_ir_release", 32'(ir0), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("c0_ov21", 32'(ov0), 32'd1);
    check("c0_od21", od0, 32'd21);

    // Bubble counter saturation, flush, reset.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) @(negedge clk);
    check("bc1_sat", 32'(bc1), 32'hFFFF);
    check("bc0_sat", 32'(bc0), 32'hFFFF);
    flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1 check("bc1_flush", 32'(bc1), 32'hFFFF);
    RST = 1'b1;
    #1 check("bc1_rst", 32'(bc1), 32'd0);

    // Asynchronous reset while FULL, then first payload after release.
    do_reset();
    in_valid = 1'b1; in_data = 32'd30; out_ready = 1'b0;
    @(negedge clk);
    in_data = 32'd31;
    @(negedge clk);
    #1 check("ar_full_ir", 32'(ir1), 32'd0);
    @(posedge clk);
    #2 RST = 1'b1;
    #1;
    check("ar_ov", 32'(ov1), 32'd0);
    check("ar_od", od1, 32'd0);
    check("ar_ir", 32'(ir1), 32'd1);
    @(negedge clk);
    RST = 1'b0;
    in_valid = 1'b1; in_data = 32'd40; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ar_first_ov", 32'(ov1), 32'd1);
    check("ar_first_od", od1, 32'd40);

    // Randomised traffic against the queue model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = $urandom;
      #1;
      check("rnd_ov1", 32'(ov1), 32'(q1.size() > 0));
      check("rnd_od1", od1, (q1.size() > 0) ? q1[0] : 32'd0);
      check("rnd_ir1", 32'(ir1), 32'(q1.size() < 2));
      check("rnd_bc1", 32'(bc1), 32'(cnt1));
      check("rnd_ov0", 32'(ov0), 32'(q0.size() > 0));
      check("rnd_od0", od0, (q0.size() > 0) ? q0[0] : 32'd0);
      check("rnd_ir0", 32'(ir0), 32'((q0.size() == 0) || out_ready));
      check("rnd_bc0", 32'(bc0), 32'(cnt0));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
